// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and width-extended load results into one registered register-file write per cycle.
// Optional WB_X0_GUARD_EN suppresses the write enable for destination register 0.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_funct3,
  output logic        ld_pending,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [31:0] write_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [36:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   ext_data, sel_data, write_data_q;
  logic [4:0]    sel_rd, rd_q;
  logic          push, pop, sel_v, we_d, reg_write_q;
  assign ld_ready   = count_q != FULL;
  assign ld_pending = count_q != '0;
  assign push       = ld_valid && ld_ready;
  assign pop        = !alu_valid && ld_pending;
  assign reg_write  = reg_write_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;
  always_comb begin
    ext_data = (ld_funct3 == 3'b000) ? {{24{ld_data[7]}}, ld_data[7:0]} :
               (ld_funct3 == 3'b001) ? {{16{ld_data[15]}}, ld_data[15:0]} :
               (ld_funct3 == 3'b100) ? {24'd0, ld_data[7:0]} :
               (ld_funct3 == 3'b101) ? {16'd0, ld_data[15:0]} : ld_data;
    sel_v    = alu_valid || pop;
    sel_rd   = alu_valid ? alu_rd : mem_q[rp_q][36:32];
    sel_data = alu_valid ? alu_result : mem_q[rp_q][31:0];
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
`ifdef WB_X0_GUARD_EN
    we_d     = sel_v && sel_rd != 5'd0;
`else
    we_d     = sel_v;
`endif
  end
  // Entry storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {ld_rd, ext_data};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      count_q     <= count_d;
      reg_write_q <= we_d;
      if (sel_v) begin
        rd_q         <= sel_rd;
        write_data_q <= sel_data;
      end
    end
  end
endmodule
